// File: rtl/unpadding_pkg.sv
// Shared hash-side definitions: stream geometry, padding limits and the unpadder state encoding.
package unpadding_pkg;

   localparam int          UNPAD_WORD_W    = 32;
   localparam int          UNPAD_BLK_WORDS = 16;
   localparam logic [7:0]  UNPAD_MARKER    = 8'h80;
   localparam logic [33:0] UNPAD_PAD_MIN   = 34'd9;
   localparam logic [33:0] UNPAD_PAD_MAX   = 34'd72;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_CHECK   = 3'd3,
      ST_TAIL    = 3'd4,
      ST_DONE    = 3'd5
   } unpad_state_t;

   function automatic logic [31:0] keep_mask(input logic [3:0] keep);
      return {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
   endfunction

endpackage

// File: rtl/unpad_word_chk.sv
// Per-word byte classification: keep mask for the first 'off' bytes, marker test at byte 'off',
// and zero test on the padding bytes of the word (all bytes when the marker lies elsewhere).
module unpad_word_chk
   import unpadding_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  off,
   input  logic        marker_here,
   output logic [3:0]  keep,
   output logic        marker_ok,
   output logic        zeros_ok
);

   // Byte 0 is the most significant byte of the word.
   always_comb begin
      keep      = 4'h0;
      marker_ok = 1'b0;
      zeros_ok  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         keep[3-i] = (3'(i) < off);
         if (marker_here && (3'(i) == off)) begin
            marker_ok = (word[8*(3-i) +: 8] == UNPAD_MARKER);
         end else begin
            zeros_ok = zeros_ok & ((marker_here && (3'(i) < off)) || (word[8*(3-i) +: 8] == 8'h00));
         end
      end
   end

endmodule

// File: rtl/unpadding.sv
// Strips SHA-style padding from a block stream: buffers two blocks, validates the length field
// and the 0x80/zero padding, and emits only the message words with byte enables.
module unpadding
   import unpadding_pkg::*;
#(
   parameter int WORD_W    = UNPAD_WORD_W,
   parameter int BLK_WORDS = UNPAD_BLK_WORDS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [WORD_W-1:0] out_data,
   output logic [3:0]        out_keep,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready,
   output logic              done,
   output logic              pad_err
);

   unpad_state_t      state_r, state_s;
   logic [WORD_W-1:0] hold_r [BLK_WORDS];
   logic [WORD_W-1:0] cur_r  [BLK_WORDS];
   logic              hold_full_r, hold_full_s;
   logic [26:0]       nb_r, nb_s;
   logic              err_r, err_s;
   logic [3:0]        wcnt_r, wcnt_s, didx_r, didx_s;
   logic [4:0]        widx_r, widx_s;
   logic              scan_r, scan_s;
   logic [6:0]        pos_r, pos_s;
   logic              cur_we_s, move_s, out_free_s;
   logic              load_s, load_last_s;
   logic [31:0]       load_data_s;
   logic [3:0]        load_keep_s;
   logic [28:0]       lb_s;
   logic [33:0]       pad_s;
   logic              chk_err_s;
   logic [6:0]        tail_pos_s;
   logic [4:0]        tail_start_s;
   logic [31:0]       win_word_s;
   logic              is_last_s, scan_ok_s;
   logic [2:0]        chk_off_s;
   logic              chk_marker_s, chk_marker_ok_s, chk_zeros_ok_s;
   logic [3:0]        chk_keep_s;

   assign out_free_s   = !out_valid || out_ready;
   assign lb_s         = cur_r[4'd15][31:3];
   assign pad_s        = {1'b0, nb_r, 6'd0} - {5'd0, lb_s};
   assign chk_err_s    = (cur_r[4'd14] != 32'h0) || (cur_r[4'd15][2:0] != 3'd0) || pad_s[33]
                         || (pad_s < UNPAD_PAD_MIN) || (pad_s > UNPAD_PAD_MAX)
                         || (!hold_full_r && (pad_s > 34'd64));
   // Marker position within the 128-byte HOLD+CUR window is 128 - PAD.
   assign tail_pos_s   = 7'd0 - pad_s[6:0];
   assign tail_start_s = hold_full_r ? 5'd0 : 5'd16;
   assign win_word_s   = widx_r[4] ? cur_r[widx_r[3:0]] : hold_r[widx_r[3:0]];
   assign is_last_s    = (({1'b0, widx_r, 2'b00} + 8'd4) >= {1'b0, pos_r});
   assign chk_off_s    = (scan_r || (is_last_s && (pos_r[1:0] != 2'd0))) ? {1'b0, pos_r[1:0]} : 3'd4;
   assign chk_marker_s = scan_r && (widx_r == pos_r[6:2]);
   assign scan_ok_s    = chk_marker_s ? (chk_marker_ok_s && chk_zeros_ok_s) : chk_zeros_ok_s;

   unpad_word_chk u_chk (
      .word        (win_word_s),
      .off         (chk_off_s),
      .marker_here (chk_marker_s),
      .keep        (chk_keep_s),
      .marker_ok   (chk_marker_ok_s),
      .zeros_ok    (chk_zeros_ok_s)
   );

   // Next-state and datapath control.
   always_comb begin
      state_s = state_r;  err_s = err_r;    nb_s = nb_r;     hold_full_s = hold_full_r;
      wcnt_s  = wcnt_r;   didx_s = didx_r;  widx_s = widx_r; scan_s = scan_r; pos_s = pos_r;
      cur_we_s = 1'b0;    move_s = 1'b0;
      load_s = 1'b0;      load_data_s = 32'h0; load_keep_s = 4'h0; load_last_s = 1'b0;
      case (state_r)
         ST_IDLE: state_s = ST_COLLECT;
         ST_COLLECT: begin
            if (in_valid && in_ready) begin
               cur_we_s = 1'b1;
               wcnt_s   = wcnt_r + 4'd1;
               if (in_last && (wcnt_r != 4'd15)) begin
                  err_s   = 1'b1;
                  state_s = ST_DONE;
               end else if (wcnt_r == 4'd15) begin
                  nb_s = nb_r + 27'd1;
                  if (in_last) begin
                     state_s = ST_CHECK;
                  end else if (!hold_full_r) begin
                     move_s      = 1'b1;
                     hold_full_s = 1'b1;
                  end else begin
                     state_s = ST_DRAIN;
                     didx_s  = 4'd0;
                  end
               end else begin
                  state_s = ST_COLLECT;
               end
            end else begin
               state_s = ST_COLLECT;
            end
         end
         ST_DRAIN: begin
            if (out_free_s) begin
               load_s      = 1'b1;
               load_data_s = hold_r[didx_r];
               load_keep_s = 4'hF;
               didx_s      = didx_r + 4'd1;
               if (didx_r == 4'd15) begin
                  move_s  = 1'b1;
                  state_s = ST_COLLECT;
               end else begin
                  state_s = ST_DRAIN;
               end
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_CHECK: begin
            if (chk_err_s) begin
               err_s   = 1'b1;
               state_s = ST_DONE;
            end else begin
               state_s = ST_TAIL;
               pos_s   = tail_pos_s;
               if ({tail_start_s, 2'b00} >= tail_pos_s) begin
                  scan_s = 1'b1;
                  widx_s = tail_pos_s[6:2];
               end else begin
                  scan_s = 1'b0;
                  widx_s = tail_start_s;
               end
            end
         end
         ST_TAIL: begin
            if (!scan_r) begin
               if (out_free_s) begin
                  load_s      = 1'b1;
                  load_data_s = win_word_s & keep_mask(chk_keep_s);
                  load_keep_s = chk_keep_s;
                  load_last_s = is_last_s;
                  if (is_last_s) begin
                     scan_s = 1'b1;
                     widx_s = pos_r[6:2];
                  end else begin
                     widx_s = widx_r + 5'd1;
                  end
               end else begin
                  widx_s = widx_r;
               end
            end else if (widx_r <= 5'd29) begin
               widx_s = widx_r + 5'd1;
               if (!scan_ok_s) begin
                  err_s = 1'b1;
               end else begin
                  err_s = err_r;
               end
            end else if (!out_valid) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_TAIL;
            end
         end
         ST_DONE: begin
            state_s     = ST_COLLECT;
            err_s       = 1'b0;
            nb_s        = 27'd0;
            hold_full_s = 1'b0;
            wcnt_s      = 4'd0;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Control state, status and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;    err_r <= 1'b0;  nb_r <= 27'd0;  hold_full_r <= 1'b0;
         wcnt_r  <= 4'd0;       didx_r <= 4'd0; widx_r <= 5'd0; scan_r <= 1'b0; pos_r <= 7'd0;
         in_ready <= 1'b0;      done <= 1'b0;   pad_err <= 1'b0;
         out_valid <= 1'b0;     out_last <= 1'b0; out_keep <= 4'h0; out_data <= '0;
      end else begin
         state_r <= state_s;    err_r <= err_s;   nb_r <= nb_s;   hold_full_r <= hold_full_s;
         wcnt_r  <= wcnt_s;     didx_r <= didx_s; widx_r <= widx_s; scan_r <= scan_s; pos_r <= pos_s;
         in_ready <= (state_s == ST_COLLECT);
         done     <= (state_s == ST_DONE);
         pad_err  <= (state_s == ST_DONE) && err_s;
         if (load_s) begin
            out_valid <= 1'b1;
            out_data  <= load_data_s;
            out_keep  <= load_keep_s;
            out_last  <= load_last_s;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= 4'h0;
            out_last  <= 1'b0;
         end
      end
   end

   // Block buffers; the word arriving this cycle is forwarded when CUR moves to HOLD on word 15.
   always_ff @(posedge clk) begin
      if (cur_we_s) cur_r[wcnt_r] <= in_data;
      if (move_s) begin
         for (int i = 0; i < BLK_WORDS; i++) begin
            hold_r[i] <= (cur_we_s && (4'(i) == wcnt_r)) ? in_data : cur_r[i];
         end
      end
   end

endmodule

// File: tb/tb_unpadding.sv
// Scoreboard bench for unpadding: directed padded messages, expected words and verdicts queued
// at stimulus time and popped by a negedge monitor.
module tb_unpadding;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] in_data = 32'h0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_valid;
   logic        out_last;
   logic        out_ready = 1'b1;
   logic        done;
   logic        pad_err;

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   logic        done_q[$];
   logic [31:0] blk [16];
   logic        prev_stall = 1'b0;
   exp_t        prev_o;

   unpadding dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_last(out_last),
      .out_ready(out_ready), .done(done), .pad_err(pad_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mword(input int k);
      return 32'hC0DE_0000 | 32'(k);
   endfunction

   task automatic push_word(input logic [31:0] d, input logic [3:0] k, input logic l);
      exp_t e;
      e.d = d; e.k = k; e.l = l;
      exp_q.push_back(e);
   endtask

   task automatic clear_blk();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
   endtask

   task automatic send_word(input logic [31:0] d, input logic l);
      int n;
      n = 0;
      in_data = d; in_valid = 1'b1; in_last = l;
      while (!in_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL in_ready_timeout: got in_ready 0 want 1 within 300 cycles");
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_block(input logic last_blk);
      for (int i = 0; i < 16; i++) send_word(blk[i], last_blk && (i == 15));
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_drained"}, 64'(exp_q.size() + done_q.size()), 64'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      exp_t a;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            a.d = out_data; a.k = out_keep; a.l = out_last;
            if (prev_stall) check("stall_hold", 64'({out_valid, a}), 64'({1'b1, prev_o}));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_word: got %h keep %h last %b want no word", out_data, out_keep, out_last);
               end else begin
                  e = exp_q.pop_front();
                  check("out_word{data,keep,last}", 64'(a), 64'(e));
               end
            end
            if (done) begin
               if (done_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done: got done 1 want 0");
               end else begin
                  check("pad_err", 64'(pad_err), 64'(done_q.pop_front()));
                  check("words_before_done", 64'(exp_q.size()), 64'd0);
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_o = a;
         end
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_in_ready"},  64'(in_ready),  64'd0);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_out_last"},  64'(out_last),  64'd0);
      check({tag, "_out_keep"},  64'(out_keep),  64'd0);
      check({tag, "_out_data"},  64'(out_data),  64'd0);
      check({tag, "_done"},      64'(done),      64'd0);
      check({tag, "_pad_err"},   64'(pad_err),   64'd0);
   endtask

   task automatic abc_message();
      clear_blk();
      blk[0] = 32'h61626380; blk[15] = 32'h0000_0018;
      push_word(32'h61626300, 4'hE, 1'b1);
      done_q.push_back(1'b0);
      send_block(1'b1);
      wait_drain("abc");
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      fork
         monitor();
         begin
            abc_message();

            // 56 bytes: marker lands in block 0 word 14, length in block 1
            for (int i = 0; i < 14; i++) push_word(mword(i), 4'hF, i == 13);
            done_q.push_back(1'b0);
            clear_blk();
            for (int i = 0; i < 14; i++) blk[i] = mword(i);
            blk[14] = 32'h8000_0000;
            send_block(1'b0);
            clear_blk();
            blk[15] = 32'h0000_01C0;
            send_block(1'b1);
            wait_drain("two_block");

            // marker missing
            clear_blk();
            blk[0] = 32'h61626300; blk[15] = 32'h0000_0018;
            push_word(32'h61626300, 4'hE, 1'b1);
            done_q.push_back(1'b1);
            send_block(1'b1);
            wait_drain("no_marker");

            // length not a whole number of bytes
            clear_blk();
            blk[0] = 32'h61626380; blk[15] = 32'h0000_0019;
            done_q.push_back(1'b1);
            send_block(1'b1);
            wait_drain("l_unaligned");

            // in_last on word 7
            done_q.push_back(1'b1);
            for (int i = 0; i < 8; i++) send_word(mword(i), i == 7);
            wait_drain("early_last");

            // empty message
            clear_blk();
            blk[0] = 32'h8000_0000;
            done_q.push_back(1'b0);
            send_block(1'b1);
            wait_drain("empty_msg");

            // 56 bytes squeezed in one block: PAD = 8
            clear_blk();
            for (int i = 0; i < 14; i++) blk[i] = mword(i);
            blk[15] = 32'h0000_01C0;
            done_q.push_back(1'b1);
            send_block(1'b1);
            wait_drain("pad_too_small");

            // 120 bytes over three blocks, downstream stalls during DRAIN
            for (int i = 0; i < 30; i++) push_word(mword(i), 4'hF, i == 29);
            done_q.push_back(1'b0);
            fork
               begin
                  clear_blk();
                  for (int i = 0; i < 16; i++) blk[i] = mword(i);
                  send_block(1'b0);
                  clear_blk();
                  for (int i = 0; i < 14; i++) blk[i] = mword(16 + i);
                  blk[14] = 32'h8000_0000;
                  send_block(1'b0);
                  clear_blk();
                  blk[15] = 32'h0000_03C0;
                  send_block(1'b1);
               end
               begin
                  int n;
                  n = 0;
                  while (!out_valid && n < 500) begin
                     @(posedge clk); #1;
                     n++;
                  end
                  check("drain_started", 64'(out_valid), 64'd1);
                  out_ready = 1'b0;
                  repeat (3) @(posedge clk);
                  #1;
                  out_ready = 1'b1;
               end
            join
            wait_drain("three_block");

            // reset while DRAIN presents word 5
            for (int i = 0; i < 5; i++) push_word(mword(100 + i), 4'hF, 1'b0);
            clear_blk();
            for (int i = 0; i < 16; i++) blk[i] = mword(100 + i);
            send_block(1'b0);
            for (int i = 0; i < 16; i++) blk[i] = mword(116 + i);
            send_block(1'b0);
            begin
               int n;
               n = 0;
               while (!(out_valid && out_data == mword(105)) && n < 200) begin
                  @(posedge clk); #1;
                  n++;
               end
               check("drain_word5_seen", 64'(out_valid && out_data == mword(105)), 64'd1);
            end
            rst_n = 1'b0;
            #1;
            check_outputs_zero("mid_drain_reset");
            check("words_before_reset", 64'(exp_q.size()), 64'd0);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            abc_message();
            repeat (10) @(posedge clk);
            #1;
         end
      join_any
      disable fork;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
